key_conditioner: RTL

//  Front-end for the board push-buttons. Synchronises the raw active-low keys, debounces each
//  one and emits clean single-cycle press/release events plus a hold-to-repeat event stream.

---
 rtl/key_conditioner_if.sv | 28 ++
 rtl/key_conditioner.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/key_conditioner_if.sv
// Key conditioner bus: raw active-low keys in, debounced level and event strobes out.
interface key_conditioner_if #(
    parameter int NUM_KEYS = 4
);
    logic [NUM_KEYS-1:0] keys;           // raw buttons, 0 = pressed, asynchronous
    logic [NUM_KEYS-1:0] pressed;        // debounced level, 1 = held
    logic [NUM_KEYS-1:0] press_pulse;    // one-cycle strobe on accepted press
    logic [NUM_KEYS-1:0] release_pulse;  // one-cycle strobe on accepted release
    logic [NUM_KEYS-1:0] repeat_pulse;   // one-cycle strobe per auto-repeat while held

    // Board side / consumer: drives the raw keys and observes the events.
    modport master (
        output keys,
        input  pressed,
        input  press_pulse,
        input  release_pulse,
        input  repeat_pulse
    );

    // Conditioner side.
    modport slave (
        input  keys,
        output pressed,
        output press_pulse,
        output release_pulse,
        output repeat_pulse
    );
endinterface

// File: rtl/key_conditioner.sv
// Push-button front end: per-key 2-flop synchroniser, debounce counter and
// hold-to-repeat FSM. Produces clean clk-domain level and single-cycle
// press/release/repeat strobes. Keys are fully independent of each other.
module key_conditioner #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 25_000_000,
    parameter int REPEAT_PERIOD   = 5_000_000
) (
    input  logic              clk,
    input  logic              rst,
    key_conditioner_if.slave  kif
);

    // Counter widths: the debounce counter only has to reach DEBOUNCE_CYCLES-1,
    // the repeat counter the larger of the two repeat intervals minus one.
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RP_W   = $clog2(RP_MAX);

    localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RP_W-1:0] DLY_LAST = RP_W'(REPEAT_DELAY - 1);
    localparam logic [RP_W-1:0] PER_LAST = RP_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_e;

    // Synchroniser chain; reset to '1' so a reset looks like all keys released.
    logic [NUM_KEYS-1:0] meta_q, meta_d;
    logic [NUM_KEYS-1:0] sync_q, sync_d;

    // Debounce state and registered event outputs.
    logic [DB_W-1:0]     db_cnt_q [NUM_KEYS];
    logic [DB_W-1:0]     db_cnt_d [NUM_KEYS];
    logic [NUM_KEYS-1:0] pressed_q, pressed_d;
    logic [NUM_KEYS-1:0] press_q, press_d;
    logic [NUM_KEYS-1:0] release_q, release_d;

    // Combinational accept strobes, shared by the debounce and repeat logic.
    logic [NUM_KEYS-1:0] press_acc;
    logic [NUM_KEYS-1:0] release_acc;

    // Repeat FSM state.
    rpt_state_e          rpt_state_q [NUM_KEYS];
    logic [RP_W-1:0]     rpt_cnt_q   [NUM_KEYS];
    logic [NUM_KEYS-1:0] repeat_q;

    // Two-stage synchroniser: only sync_q is ever looked at by downstream logic.
    always_comb begin
        meta_d = kif.keys;
        sync_d = meta_q;
    end

    // Debounce: count how long the synchronised level disagrees with the
    // accepted level; accept (toggle) once it has disagreed for the full window.
    always_comb begin
        press_acc   = '0;
        release_acc = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            db_cnt_d[i] = '0;
            // Keys are active-low, so the candidate "pressed" level is ~sync.
            if (~sync_q[i] == pressed_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_LAST) begin
                db_cnt_d[i]    = '0;
                press_acc[i]   = ~pressed_q[i];
                release_acc[i] =  pressed_q[i];
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
            end
        end
        // Exactly one of press/release can fire per key, so the level simply toggles.
        pressed_d = pressed_q ^ (press_acc | release_acc);
        press_d   = press_acc;
        release_d = release_acc;
    end

    // Synchroniser, debounce counters and level/press/release output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q    <= '1;
            sync_q    <= '1;
            pressed_q <= '0;
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            meta_q    <= meta_d;
            sync_q    <= sync_d;
            pressed_q <= pressed_d;
            press_q   <= press_d;
            release_q <= release_d;
            for (int i = 0; i < NUM_KEYS; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

    // Hold-to-repeat FSM per key: wait REPEAT_DELAY after the press, then strobe
    // every REPEAT_PERIOD. A release always wins and suppresses that cycle's repeat.
    always_ff @(posedge clk) begin
        if (rst) begin
            repeat_q <= '0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                rpt_state_q[i] <= RPT_IDLE;
                rpt_cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                repeat_q[i] <= 1'b0;
                if (release_acc[i]) begin
                    rpt_state_q[i] <= RPT_IDLE;
                    rpt_cnt_q[i]   <= '0;
                end else begin
                    case (rpt_state_q[i])
                        RPT_IDLE: begin
                            rpt_cnt_q[i] <= '0;
                            if (press_acc[i]) begin
                                rpt_state_q[i] <= RPT_DELAY;
                            end
                        end
                        RPT_DELAY: begin
                            if (rpt_cnt_q[i] == DLY_LAST) begin
                                repeat_q[i]    <= 1'b1;
                                rpt_state_q[i] <= RPT_REPEAT;
                                rpt_cnt_q[i]   <= '0;
                            end else begin
                                rpt_cnt_q[i] <= rpt_cnt_q[i] + RP_W'(1);
                            end
                        end
                        RPT_REPEAT: begin
                            if (rpt_cnt_q[i] == PER_LAST) begin
                                repeat_q[i]  <= 1'b1;
                                rpt_cnt_q[i] <= '0;
                            end else begin
                                rpt_cnt_q[i] <= rpt_cnt_q[i] + RP_W'(1);
                            end
                        end
                        default: begin
                            rpt_state_q[i] <= RPT_IDLE;
                            rpt_cnt_q[i]   <= '0;
                        end
                    endcase
                end
            end
        end
    end

    assign kif.pressed       = pressed_q;
    assign kif.press_pulse   = press_q;
    assign kif.release_pulse = release_q;
    assign kif.repeat_pulse  = repeat_q;

endmodule
